// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with frame-boundary run/stop control.
// Optional border overlay is enabled by defining VGA_TIMING_BORDER_EN.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_LEAD = 1,
  parameter int RGB_W    = 12,
  parameter int CNT_W    = 12,
  parameter logic [RGB_W-1:0] BORDER_COLOR = {RGB_W{1'b1}}
) (
  input  logic             vga_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic [RGB_W-1:0] pix_data,
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] vga_rgb,
  output logic             frame_start,
  output logic             running
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int H_ACT_S = H_SYNC + H_BACK;
  localparam int H_ACT_E = H_ACT_S + H_ACTIVE;
  localparam int V_ACT_S = V_SYNC + V_BACK;
  localparam int V_ACT_E = V_ACT_S + V_ACTIVE;

  localparam logic [CNT_W-1:0] C_H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] C_H_SYNC = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] C_V_SYNC = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] C_H_AS   = CNT_W'(H_ACT_S);
  localparam logic [CNT_W-1:0] C_H_AE   = CNT_W'(H_ACT_E);
  localparam logic [CNT_W-1:0] C_V_AS   = CNT_W'(V_ACT_S);
  localparam logic [CNT_W-1:0] C_V_AE   = CNT_W'(V_ACT_E);

  // Lead arithmetic is one bit wider so h_cnt+PIX_LEAD cannot wrap
  localparam logic [CNT_W:0] C_LEAD  = (CNT_W+1)'(PIX_LEAD);
  localparam logic [CNT_W:0] C_RQ_AS = (CNT_W+1)'(H_ACT_S);
  localparam logic [CNT_W:0] C_RQ_AE = (CNT_W+1)'(H_ACT_E);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic [RGB_W-1:0] r_rgb;
  logic             r_frame_start;

  logic             w_run;
  logic             w_line_last;
  logic             w_frame_last;
  logic             w_h_act;
  logic             w_v_act;
  logic             w_act;
  logic [CNT_W:0]   w_h_lead;
  logic             w_req_h;
  logic             w_req;
  logic [RGB_W-1:0] w_rgb_nxt;

  assign w_run        = (r_state == S_RUN);
  assign w_line_last  = (r_h_cnt == C_H_LAST);
  assign w_frame_last = w_line_last && (r_v_cnt == C_V_LAST);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stop is only honoured at the frame end so a frame is never cut short
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (en) w_state_nxt = S_RUN;
      S_RUN:  if (w_frame_last && !en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!w_run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_line_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_frame_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign w_h_act = (r_h_cnt >= C_H_AS) && (r_h_cnt < C_H_AE);
  assign w_v_act = (r_v_cnt >= C_V_AS) && (r_v_cnt < C_V_AE);
  assign w_act   = w_run && w_h_act && w_v_act;

  assign w_h_lead = {1'b0, r_h_cnt} + C_LEAD;
  assign w_req_h  = (w_h_lead >= C_RQ_AS) && (w_h_lead < C_RQ_AE);
  assign w_req    = w_run && w_v_act && w_req_h;

  assign pix_req = w_req;
  assign pix_x   = w_req ? CNT_W'(w_h_lead - C_RQ_AS) : '0;
  assign pix_y   = w_req ? (r_v_cnt - C_V_AS) : '0;

`ifdef VGA_TIMING_BORDER_EN
  logic w_border;
  assign w_border = (r_h_cnt == C_H_AS)
                 || (r_h_cnt == C_H_AE - 1'b1)
                 || (r_v_cnt == C_V_AS)
                 || (r_v_cnt == C_V_AE - 1'b1);
  always_comb begin
    w_rgb_nxt = '0;
    if (w_act) w_rgb_nxt = w_border ? BORDER_COLOR : pix_data;
  end
`else
  always_comb begin
    w_rgb_nxt = '0;
    if (w_act) w_rgb_nxt = pix_data;
  end
`endif

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= (w_run && r_h_cnt < C_H_SYNC) ? HS_POL : ~HS_POL;
      r_vsync       <= (w_run && r_v_cnt < C_V_SYNC) ? VS_POL : ~VS_POL;
      r_de          <= w_act;
      r_rgb         <= w_rgb_nxt;
      r_frame_start <= w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign vga_rgb     = r_rgb;
  assign frame_start = r_frame_start;
  assign running     = w_run;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 15x8 frame, lead 1 and lead 5.
// Border expectations follow VGA_TIMING_BORDER_EN when it is defined.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic [11:0] pd1 = 12'h000;
  logic [11:0] sr5 [0:4] = '{default: 12'h000};

  logic        rq1, hs1, vs1, de1, fs1, run1;
  logic [11:0] px1, py1, rgb1;
  logic        rq5, hs5, vs5, de5, fs5, run5;
  logic [11:0] px5, py5, rgb5;

  int n_assert = 0;
  int n_fail = 0;
  int hs_low = 0, vs_low = 0, de_hi = 0, fs_cnt = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LEAD(1),
    .RGB_W(12), .CNT_W(12), .BORDER_COLOR(12'hFFF)
  ) dut1 (
    .vga_clk(clk), .sys_rst_n(rst_n), .en(en),
    .pix_data(pd1), .pix_req(rq1), .pix_x(px1),
    .pix_y(py1), .hsync(hs1), .vsync(vs1), .de(de1),
    .vga_rgb(rgb1), .frame_start(fs1), .running(run1)
  );

  vga_timing_gen #(
    .H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LEAD(5),
    .RGB_W(12), .CNT_W(12), .BORDER_COLOR(12'hFFF)
  ) dut5 (
    .vga_clk(clk), .sys_rst_n(rst_n), .en(en),
    .pix_data(sr5[4]), .pix_req(rq5), .pix_x(px5),
    .pix_y(py5), .hsync(hs5), .vsync(vs5), .de(de5),
    .vga_rgb(rgb5), .frame_start(fs5), .running(run5)
  );

  // Picture-generator stand-ins with 1 and 5 cycles of latency
  always @(posedge clk) begin
    pd1 <= {py1[3:0], px1[7:0]};
    sr5[0] <= {py5[3:0], px5[7:0]};
    for (int i = 1; i < 5; i++) sr5[i] <= sr5[i-1];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_hsync", hs1, 1);
    chk("rst_vsync", vs1, 1);
    chk("rst_de", de1, 0);
    chk("rst_rgb", rgb1, 0);
    chk("rst_fs", fs1, 0);
    chk("rst_req", rq1, 0);
    chk("rst_px", px1, 0);
    chk("rst_py", py1, 0);
    chk("rst_run", run1, 0);
    chk("rst_run5", run5, 0);
    chk("rst_req5", rq5, 0);
  endtask

  // t = clocks since entering RUN; counters at t, outputs show t-1
  task automatic check_cycle(input int t);
    int p, q, hp, vp, hq, vq, col, row;
    logic act, r1, r5, brd;
    logic [11:0] rgb;
    p = t % 120;
    q = (t + 119) % 120;
    hp = p % 15; vp = p / 15;
    hq = q % 15; vq = q / 15;
    act = (vq >= 3) && (vq < 7) && (hq >= 5) && (hq < 13);
    col = hq - 5;
    row = vq - 3;
    brd = 1'b0;
`ifdef VGA_TIMING_BORDER_EN
    brd = (col == 0) || (col == 7) || (row == 0) || (row == 3);
`endif
    rgb = !act ? 12'h000 : brd ? 12'hFFF : {row[3:0], col[7:0]};
    r1 = (vp >= 3) && (vp < 7) && (hp >= 4) && (hp < 12);
    r5 = (vp >= 3) && (vp < 7) && (hp < 8);
    chk("run", run1, 1);
    chk("req1", rq1, r1);
    chk("px1", px1, r1 ? hp - 4 : 0);
    chk("py1", py1, r1 ? vp - 3 : 0);
    chk("req5", rq5, r5);
    chk("px5", px5, r5 ? hp : 0);
    chk("py5", py5, r5 ? vp - 3 : 0);
    chk("hsync", hs1, (hq < 2) ? 0 : 1);
    chk("vsync", vs1, (vq < 1) ? 0 : 1);
    chk("de", de1, act);
    chk("fs", fs1, q == 0);
    chk("rgb1", rgb1, rgb);
    chk("de5", de5, act);
    chk("rgb5", rgb5, rgb);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset();

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_run", run1, 0);
    chk("idle_hs", hs1, 1);
    chk("idle_fs", fs1, 0);

    en = 1'b1;
    @(negedge clk);
    chk("start_run", run1, 1);
    chk("start_fs", fs1, 0);

    for (int t = 1; t < 360; t++) begin
      @(negedge clk);
      check_cycle(t);
      if (t <= 120) begin
        hs_low += (hs1 == 1'b0) ? 1 : 0;
        vs_low += (vs1 == 1'b0) ? 1 : 0;
        de_hi  += de1 ? 1 : 0;
        fs_cnt += fs1 ? 1 : 0;
      end
      if (t == 120) begin
        chk("cnt_hs_low", hs_low, 16);
        chk("cnt_vs_low", vs_low, 15);
        chk("cnt_de", de_hi, 32);
        chk("cnt_fs", fs_cnt, 1);
      end
      if (t == 150) en = 1'b0;
      if (t == 180) en = 1'b1;
      if (t == 289) en = 1'b0;
    end

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stop_run", run1, 0);
      chk("stop_hs", hs1, 1);
      chk("stop_vs", vs1, 1);
      chk("stop_de", de1, 0);
      chk("stop_fs", fs1, 0);
      chk("stop_req", rq1, 0);
    end

    en = 1'b1;
    @(negedge clk);
    chk("rs_run", run1, 1);
    for (int t = 1; t <= 52; t++) begin
      @(negedge clk);
      check_cycle(t);
    end
    chk("pre_rst_de", de1, 1);
    chk("pre_rst_req", rq1, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    @(negedge clk);
    chk_reset();

    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_run", run1, 1);
    chk("rel_fs", fs1, 0);
    for (int t = 1; t <= 125; t++) begin
      @(negedge clk);
      check_cycle(t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
